frame_ctr_checker: RTL and testbench

//  Read-side partner of the frame counter: drains 32-bit words from the host-loopback FIFO
//  and verifies they form an incrementing sequence, as produced by the write-side counter.

---
 rtl/frame_ctr_checker_pkg.sv | 16 +
 rtl/frame_ctr_checker_if.sv | 24 ++
 rtl/frame_ctr_checker_sat_counter32.sv | 31 +++
 rtl/frame_ctr_checker.sv | 148 ++++++++++++++
 tb/tb_frame_ctr_checker.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/frame_ctr_checker_pkg.sv
// Shared types and constants for the frame counter checker.
//   state_t    : checker FSM states (IDLE, SYNC, CHECK)
//   DW_DEFAULT : default data/counter width
//   SAT_MAX    : saturation value of the 32-bit statistics counters
package frame_chk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        CHECK = 2'd2
    } state_t;

    localparam int          DW_DEFAULT = 32;
    localparam logic [31:0] SAT_MAX    = 32'hFFFF_FFFF;

endpackage

// File: rtl/frame_ctr_checker_if.sv
// FIFO read-port bundle between the loopback FIFO and the checker.
//   fifo_empty : FIFO empty flag          (FIFO -> checker)
//   fifo_rd_en : read strobe              (checker -> FIFO)
//   fifo_dout  : read data, valid 1 cycle after fifo_rd_en (FIFO -> checker)
// Modports: master = reader (checker), slave = FIFO.
interface frame_ctr_checker_if #(
    parameter int DW = 32
);
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_dout;

    modport master (
        input  fifo_empty,
        input  fifo_dout,
        output fifo_rd_en
    );

    modport slave (
        output fifo_empty,
        output fifo_dout,
        input  fifo_rd_en
    );
endinterface

// File: rtl/frame_ctr_checker_sat_counter32.sv
// 32-bit saturating event counter.
//   clk   : clock
//   rst_n : asynchronous active-low reset (count -> 0)
//   inc   : count one event
//   clr   : synchronous clear, takes priority over inc
//   count : current value, sticks at SAT_MAX
module sat_counter32
    import frame_chk_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc,
    input  logic        clr,
    output logic [31:0] count
);

    logic [31:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= 32'd0;
        end else if (clr) begin
            count_reg <= 32'd0;
        end else if (inc && (count_reg != SAT_MAX)) begin
            count_reg <= count_reg + 32'd1;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/frame_ctr_checker.sv
// Read-side sequence checker: drains words from the loopback FIFO and verifies
// they form an incrementing (mod 2**DW) sequence.
//   clk, rst_n  : clock, asynchronous active-low reset
//   en          : check enable, gates new FIFO reads
//   clr         : synchronous clear of statistics; back to SYNC (or IDLE if en=0)
//   fifo        : FIFO read port (master modport)
//   locked      : LOCK_RUN consecutive matches since last error/clear
//   err_pulse   : one-cycle pulse per mismatching word
//   err_count   : saturating mismatch count
//   word_count  : words checked including the sync word (wraps)
//   first_bad   : first mismatching word since reset/clear
//   first_exp   : expected value at that first mismatch
module frame_ctr_checker
    import frame_chk_pkg::*;
#(
    parameter int DW       = DW_DEFAULT,
    parameter int LOCK_RUN = 4,
    parameter bit RESYNC   = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 clr,
    frame_ctr_checker_if.master  fifo,
    output logic                 locked,
    output logic                 err_pulse,
    output logic [31:0]          err_count,
    output logic [31:0]          word_count,
    output logic [DW-1:0]        first_bad,
    output logic [DW-1:0]        first_exp
);

    localparam int RW = $clog2(LOCK_RUN + 1);

    state_t        state_reg, state_next;
    logic          rd_valid_reg;
    logic [DW-1:0] expected_reg, expected_next;
    logic [RW-1:0] run_reg, run_next;
    logic          locked_reg, locked_next;
    logic          err_pulse_reg;
    logic [31:0]   word_count_reg, word_count_next;
    logic [DW-1:0] first_bad_reg, first_bad_next;
    logic [DW-1:0] first_exp_reg, first_exp_next;

    logic          take;
    logic          is_sync;
    logic          mismatch;
    logic          match;
    logic [DW-1:0] word;

    assign fifo.fifo_rd_en = en & ~fifo.fifo_empty & ((state_reg != IDLE) | en);

    assign word = fifo.fifo_dout;
    // clr discards a word that lands in the same cycle
    assign take     = rd_valid_reg & ~clr;
    assign is_sync  = take & (state_reg == SYNC);
    assign mismatch = take & (state_reg == CHECK) & (word != expected_reg);
    assign match    = take & (state_reg == CHECK) & (word == expected_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            rd_valid_reg   <= 1'b0;
            expected_reg   <= '0;
            run_reg        <= '0;
            locked_reg     <= 1'b0;
            err_pulse_reg  <= 1'b0;
            word_count_reg <= 32'd0;
            first_bad_reg  <= '0;
            first_exp_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            rd_valid_reg   <= fifo.fifo_rd_en;
            expected_reg   <= expected_next;
            run_reg        <= run_next;
            locked_reg     <= locked_next;
            err_pulse_reg  <= mismatch;
            word_count_reg <= word_count_next;
            first_bad_reg  <= first_bad_next;
            first_exp_reg  <= first_exp_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        expected_next   = expected_reg;
        run_next        = run_reg;
        locked_next     = locked_reg;
        word_count_next = word_count_reg;
        first_bad_next  = first_bad_reg;
        first_exp_next  = first_exp_reg;

        if (clr) begin
            state_next      = en ? SYNC : IDLE;
            run_next        = '0;
            locked_next     = 1'b0;
            word_count_next = 32'd0;
            first_bad_next  = '0;
            first_exp_next  = '0;
        end else begin
            case (state_reg)
                IDLE:    if (en) state_next = SYNC;
                SYNC:    if (rd_valid_reg) state_next = CHECK;
                default: state_next = CHECK;
            endcase

            if (is_sync || match || mismatch) begin
                word_count_next = word_count_reg + 32'd1;
            end

            if (is_sync) begin
                expected_next = word + DW'(1);
            end else if (match) begin
                expected_next = expected_reg + DW'(1);
                if (run_reg != RW'(LOCK_RUN)) begin
                    run_next = run_reg + RW'(1);
                end
                if (run_next == RW'(LOCK_RUN)) begin
                    locked_next = 1'b1;
                end
            end else if (mismatch) begin
                expected_next = RESYNC ? (word + DW'(1)) : (expected_reg + DW'(1));
                run_next      = '0;
                locked_next   = 1'b0;
                // Only the first error since reset/clear is kept for debug
                if (err_count == 32'd0) begin
                    first_bad_next = word;
                    first_exp_next = expected_reg;
                end
            end
        end
    end

    sat_counter32 u_err_count (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (mismatch),
        .clr   (clr),
        .count (err_count)
    );

    assign locked     = locked_reg;
    assign err_pulse  = err_pulse_reg;
    assign word_count = word_count_reg;
    assign first_bad  = first_bad_reg;
    assign first_exp  = first_exp_reg;

endmodule

// File: tb/tb_frame_ctr_checker.sv
// Bench for frame_ctr_checker: one instance with RESYNC=1 and one with RESYNC=0
// share a FIFO model; expected per-word results go into per-instance queues and
// are compared whenever that instance's word_count advances.
module tb_frame_ctr_checker;

    typedef struct {
        logic [31:0] wc;
        logic [31:0] ec;
        logic        pulse;
        logic        locked;
    } exp_t;

    typedef struct {
        bit          clr_before;
        logic [31:0] word;
        bit          p1;
        bit          l1;
        bit          p0;
        bit          l0;
    } row_t;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        clr;
    logic        force_empty;

    logic        locked_o     [2];
    logic        err_pulse_o  [2];
    logic [31:0] err_count_o  [2];
    logic [31:0] word_count_o [2];
    logic [31:0] first_bad_o  [2];
    logic [31:0] first_exp_o  [2];

    logic [31:0] mem [0:255];
    int          wr_ptr;
    int          rd_ptr;
    logic [31:0] dout_reg;
    logic        tb_empty;

    int          checks;
    int          failures;
    bit          mon_en;
    exp_t        q0[$];
    exp_t        q1[$];
    logic [31:0] cnt_wc [2];
    logic [31:0] cnt_ec [2];
    logic [31:0] prev_wc [2];
    row_t        vec[$];

    frame_ctr_checker_if #(.DW(32)) bus0 ();
    frame_ctr_checker_if #(.DW(32)) bus1 ();

    assign tb_empty        = (rd_ptr == wr_ptr) || force_empty;
    assign bus0.fifo_empty = tb_empty;
    assign bus1.fifo_empty = tb_empty;
    assign bus0.fifo_dout  = dout_reg;
    assign bus1.fifo_dout  = dout_reg;

    frame_ctr_checker #(.DW(32), .LOCK_RUN(4), .RESYNC(1'b1)) dut_r1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .clr        (clr),
        .fifo       (bus0),
        .locked     (locked_o[0]),
        .err_pulse  (err_pulse_o[0]),
        .err_count  (err_count_o[0]),
        .word_count (word_count_o[0]),
        .first_bad  (first_bad_o[0]),
        .first_exp  (first_exp_o[0])
    );

    frame_ctr_checker #(.DW(32), .LOCK_RUN(4), .RESYNC(1'b0)) dut_r0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .clr        (clr),
        .fifo       (bus1),
        .locked     (locked_o[1]),
        .err_pulse  (err_pulse_o[1]),
        .err_count  (err_count_o[1]),
        .word_count (word_count_o[1]),
        .first_bad  (first_bad_o[1]),
        .first_exp  (first_exp_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO model: standard read, data one cycle after the strobe
    always @(posedge clk) begin
        if (bus0.fifo_rd_en) begin
            dout_reg <= mem[rd_ptr];
            rd_ptr   <= rd_ptr + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Scoreboard monitor: a record is consumed whenever word_count advances
    always @(negedge clk) begin
        exp_t e;
        bit   got;
        for (int k = 0; k < 2; k++) begin
            if (mon_en && (word_count_o[k] != prev_wc[k]) && (word_count_o[k] != 32'd0)) begin
                got = 1'b0;
                if (k == 0 && q0.size() > 0) begin
                    e = q0.pop_front();
                    got = 1'b1;
                end else if (k == 1 && q1.size() > 0) begin
                    e = q1.pop_front();
                    got = 1'b1;
                end
                if (!got) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected_word dut%0d word_count=%0d required=no new word", k, word_count_o[k]);
                end else begin
                    chk($sformatf("sb_word_count_dut%0d", k), word_count_o[k], e.wc);
                    chk($sformatf("sb_err_count_dut%0d_wc%0d", k, e.wc), err_count_o[k], e.ec);
                    chk($sformatf("sb_err_pulse_dut%0d_wc%0d", k, e.wc), 32'(err_pulse_o[k]), 32'(e.pulse));
                    chk($sformatf("sb_locked_dut%0d_wc%0d", k, e.wc), 32'(locked_o[k]), 32'(e.locked));
                end
            end else if (mon_en) begin
                chk($sformatf("no_word_pulse_dut%0d", k), 32'(err_pulse_o[k]), 32'd0);
            end
            prev_wc[k] = word_count_o[k];
        end
    end

    // Read strobe must never fire on empty or with en low
    always @(negedge clk) begin
        #2;
        if (tb_empty || !en) begin
            chk("rd_en_guard", 32'(bus0.fifo_rd_en), 32'd0);
            chk("rd_en_guard_r0", 32'(bus1.fifo_rd_en), 32'd0);
        end
    end

    task automatic push_raw(input logic [31:0] w);
        mem[wr_ptr] = w;
        wr_ptr++;
    endtask

    task automatic push_word(input logic [31:0] w, input bit p1, input bit l1, input bit p0, input bit l0);
        exp_t e;
        push_raw(w);
        cnt_wc[0] = cnt_wc[0] + 32'd1;
        cnt_ec[0] = cnt_ec[0] + 32'(p1);
        e.wc = cnt_wc[0]; e.ec = cnt_ec[0]; e.pulse = p1; e.locked = l1;
        q0.push_back(e);
        cnt_wc[1] = cnt_wc[1] + 32'd1;
        cnt_ec[1] = cnt_ec[1] + 32'(p0);
        e.wc = cnt_wc[1]; e.ec = cnt_ec[1]; e.pulse = p0; e.locked = l0;
        q1.push_back(e);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (!((rd_ptr == wr_ptr) && q0.size() == 0 && q1.size() == 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout_%s actual=%0d pending required=0", name, q0.size() + q1.size());
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic clr_pulse_and_check(input string name);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s_wc_dut%0d", name, k), word_count_o[k], 32'd0);
            chk($sformatf("%s_ec_dut%0d", name, k), err_count_o[k], 32'd0);
            chk($sformatf("%s_locked_dut%0d", name, k), 32'(locked_o[k]), 32'd0);
            chk($sformatf("%s_first_bad_dut%0d", name, k), first_bad_o[k], 32'd0);
            chk($sformatf("%s_first_exp_dut%0d", name, k), first_exp_o[k], 32'd0);
            chk($sformatf("%s_pulse_dut%0d", name, k), 32'(err_pulse_o[k]), 32'd0);
            cnt_wc[k] = 32'd0;
            cnt_ec[k] = 32'd0;
        end
    endtask

    task automatic add_row(input bit c, input logic [31:0] w, input bit p1, input bit l1, input bit p0, input bit l0);
        row_t r;
        r.clr_before = c; r.word = w; r.p1 = p1; r.l1 = l1; r.p0 = p0; r.l0 = l0;
        vec.push_back(r);
    endtask

    task automatic check_all_zero(input string name);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s_wc_dut%0d", name, k), word_count_o[k], 32'd0);
            chk($sformatf("%s_ec_dut%0d", name, k), err_count_o[k], 32'd0);
            chk($sformatf("%s_locked_dut%0d", name, k), 32'(locked_o[k]), 32'd0);
            chk($sformatf("%s_pulse_dut%0d", name, k), 32'(err_pulse_o[k]), 32'd0);
            chk($sformatf("%s_first_bad_dut%0d", name, k), first_bad_o[k], 32'd0);
            chk($sformatf("%s_first_exp_dut%0d", name, k), first_exp_o[k], 32'd0);
        end
    endtask

    initial begin
        int n;
        checks = 0; failures = 0; mon_en = 1'b0;
        wr_ptr = 0; rd_ptr = 0; dout_reg = 32'd0;
        rst_n = 1'b0; en = 1'b0; clr = 1'b0; force_empty = 1'b0;
        for (int k = 0; k < 2; k++) begin
            cnt_wc[k] = 32'd0; cnt_ec[k] = 32'd0; prev_wc[k] = 32'd0;
        end

        // Vector table: clean run, wrap, drop (RESYNC=1 / RESYNC=0)
        for (int i = 0; i < 10; i++) add_row(1'b0, 32'd100 + 32'(i), 1'b0, (i >= 4), 1'b0, (i >= 4));
        add_row(1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b0);
        add_row(1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0);
        add_row(1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0);
        add_row(1'b0, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0);
        add_row(1'b1, 32'd5,  1'b0, 1'b0, 1'b0, 1'b0);
        add_row(1'b0, 32'd6,  1'b0, 1'b0, 1'b0, 1'b0);
        add_row(1'b0, 32'd8,  1'b1, 1'b0, 1'b1, 1'b0);
        add_row(1'b0, 32'd9,  1'b0, 1'b0, 1'b1, 1'b0);
        add_row(1'b0, 32'd10, 1'b0, 1'b0, 1'b1, 1'b0);
        add_row(1'b0, 32'd11, 1'b0, 1'b0, 1'b1, 1'b0);
        add_row(1'b0, 32'd12, 1'b0, 1'b1, 1'b1, 1'b0);

        repeat (3) @(negedge clk);
        check_all_zero("reset_state");
        rst_n = 1'b1;
        @(negedge clk);
        en = 1'b1;
        mon_en = 1'b1;

        for (int i = 0; i < vec.size(); i++) begin
            if (vec[i].clr_before) begin
                wait_drain($sformatf("row%0d", i));
                clr_pulse_and_check($sformatf("clr_row%0d", i));
            end
            push_word(vec[i].word, vec[i].p1, vec[i].l1, vec[i].p0, vec[i].l0);
            @(negedge clk);
        end
        wait_drain("drop");
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("drop_first_bad_dut%0d", k), first_bad_o[k], 32'd8);
            chk($sformatf("drop_first_exp_dut%0d", k), first_exp_o[k], 32'd7);
        end
        chk("drop_err_count_r1", err_count_o[0], 32'd1);
        chk("drop_err_count_r0", err_count_o[1], 32'd5);

        // Empty toggling and en drops with words in flight
        clr_pulse_and_check("clr_empty_en");
        for (int i = 0; i < 8; i++) push_word(32'd200 + 32'(i), 1'b0, (i >= 4), 1'b0, (i >= 4));
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            en          = ($urandom_range(0, 3) != 0);
            force_empty = ($urandom_range(0, 2) == 0);
        end
        @(negedge clk);
        en = 1'b1;
        force_empty = 1'b0;
        wait_drain("empty_en");
        chk("empty_en_wc", word_count_o[0], 32'd8);

        // clr coincident with a valid word: that word is discarded, next one syncs
        clr_pulse_and_check("clr_pre6");
        push_word(32'd10, 1'b0, 1'b0, 1'b0, 1'b0);
        push_word(32'd11, 1'b0, 1'b0, 1'b0, 1'b0);
        push_word(32'd99, 1'b1, 1'b0, 1'b1, 1'b0);
        push_raw(32'd50);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (rd_ptr != wr_ptr && n < 50);
        chk("clr_word_read_in_time", 32'(rd_ptr == wr_ptr), 32'd1);
        clr_pulse_and_check("clr_on_word50");
        push_word(32'd77, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        push_word(32'd78, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_drain("sync77");
        chk("sync77_wc", word_count_o[0], 32'd2);
        chk("sync77_ec", err_count_o[0], 32'd0);

        // Async reset while a mismatching word is in flight
        mon_en = 1'b0;
        clr_pulse_and_check("clr_pre_reset");
        push_raw(32'd1); push_raw(32'd2); push_raw(32'd3); push_raw(32'd4); push_raw(32'd99);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (word_count_o[0] != 32'd4 && n < 50);
        chk("reset_setup_wc", word_count_o[0], 32'd4);
        chk("reset_setup_locked", 32'(locked_o[0]), 32'd0);
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("post_reset_pulse_c%0d", c), 32'(err_pulse_o[0] | err_pulse_o[1]), 32'd0);
            chk($sformatf("post_reset_ec_c%0d", c), err_count_o[0] | err_count_o[1], 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
